// File: rtl/gpio_reg_pkg.sv
// rtl/gpio_reg_pkg.sv - GPIO register block offsets
package gpio_reg_pkg;

    localparam logic [31:0] GPIO_OUT_OFFSET    = 32'h0000_0004;
    localparam logic [31:0] GPIO_TOGGLE_OFFSET = 32'h0000_000C;

endpackage

// File: rtl/gpio_seq_pkg.sv
// rtl/gpio_seq_pkg.sv - sequencer states, pattern entry type and address helper
package gpio_seq_pkg;

    import gpio_reg_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        WAIT = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic        toggle;
        logic [31:0] data;
    } seq_entry_t;

    function automatic logic [31:0] entry_addr(input logic [31:0] base, input logic toggle);
        return base + (toggle ? GPIO_TOGGLE_OFFSET : GPIO_OUT_OFFSET);
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI manager port channel types
package obi_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_rsp_t;

endpackage

// File: rtl/gpio_obi_sequencer.sv
// rtl/gpio_obi_sequencer.sv - OBI manager replaying a stored pattern into GPIO OUT/TOGGLE
module gpio_obi_sequencer
    import gpio_seq_pkg::*;
    import obi_pkg::*;
#(
    parameter int unsigned GpioCount  = 16,
    parameter int unsigned Depth      = 8,
    parameter int unsigned TimerWidth = 16,
    parameter logic [31:0] TargetAddr = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic                         push_toggle_i,
    input  logic [GpioCount-1:0]         push_data_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         loop_i,
    input  logic [TimerWidth-1:0]        interval_i,
    output obi_req_t                     obi_req_o,
    input  obi_rsp_t                     obi_rsp_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(Depth):0]       count_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned CntW = IdxW + 1;

    seq_state_e            state_q, state_d;
    seq_entry_t            entries [Depth];
    seq_entry_t            cur;
    logic [CntW-1:0]       count_q, count_eff;
    logic [IdxW-1:0]       idx_q;
    logic [TimerWidth-1:0] timer_q, interval_q;
    logic                  loop_q, err_q, done_q, stop_q;
    logic                  idle, push_fire, clear_fire, start_fire, last, stop_pend;
    logic                  begin_play, advance, set_err, done_d;
    logic                  unused_rsp;

    assign unused_rsp   = ^{obi_rsp_i.r.rdata, obi_rsp_i.r.rid};

    assign idle         = (state_q == IDLE);
    assign busy_o       = ~idle;
    assign push_ready_o = idle && (count_q < CntW'(Depth));
    assign push_fire    = push_valid_i & push_ready_o;
    assign clear_fire   = clear_i & idle;
    // Clear beats start in the same cycle; a same-cycle push joins the sequence.
    assign start_fire   = start_i & idle & ~clear_fire;
    assign count_eff    = count_q + CntW'(push_fire);
    assign cur          = entries[idx_q];
    assign last         = (CntW'(idx_q) == count_q - CntW'(1));
    assign stop_pend    = stop_q | stop_i;

    assign done_o       = done_q;
    assign err_o        = err_q;
    assign count_o      = count_q;

    // Next-state, OBI request drive and control strobes for the register blocks.
    always_comb begin
        state_d    = state_q;
        obi_req_o  = '0;
        begin_play = 1'b0;
        advance    = 1'b0;
        set_err    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_fire) begin
                    if (count_eff != '0) begin
                        begin_play = 1'b1;
                        state_d    = REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            REQ: begin
                obi_req_o.req     = 1'b1;
                obi_req_o.a.we    = 1'b1;
                obi_req_o.a.be    = '1;
                obi_req_o.a.aid   = '0;
                obi_req_o.a.addr  = entry_addr(TargetAddr, cur.toggle);
                obi_req_o.a.wdata = cur.data;
                if (obi_rsp_i.gnt) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                obi_req_o.rready = 1'b1;
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.r.err) begin
                        set_err = 1'b1;
                        state_d = IDLE;
                    end else if (stop_pend || (last && !loop_q)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = (interval_q == '0) ? REQ : WAIT;
                    end
                end
            end
            WAIT: begin
                if (stop_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timer_q <= TimerWidth'(1)) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pattern storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_fire && !clear_fire) begin
            entries[count_q[IdxW-1:0]] <= '{toggle: push_toggle_i, data: 32'(push_data_i)};
        end
    end

    // Stored entry count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_fire) begin
            count_q <= '0;
        end else if (push_fire) begin
            count_q <= count_q + CntW'(1);
        end
    end

    // Playback bookkeeping: index, interval timer, latched settings, flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            timer_q    <= '0;
            interval_q <= '0;
            loop_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            done_q <= done_d;
            if (begin_play) begin
                idx_q      <= '0;
                loop_q     <= loop_i;
                interval_q <= interval_i;
                err_q      <= 1'b0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (advance) begin
                idx_q   <= last ? '0 : idx_q + IdxW'(1);
                timer_q <= interval_q;
            end else if (state_q == WAIT) begin
                timer_q <= timer_q - TimerWidth'(1);
            end
            if ((state_q == REQ || state_q == RSP) && stop_i) begin
                stop_q <= 1'b1;
            end
            if (state_d == IDLE) begin
                stop_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_obi_sequencer.sv
// tb/tb_gpio_obi_sequencer.sv - self-checking bench for gpio_obi_sequencer
module tb_gpio_obi_sequencer;
    import obi_pkg::*;

    localparam logic [31:0] BASE    = 32'h2000_0000;
    localparam logic [31:0] OUT_OFF = 32'h0000_0004;
    localparam logic [31:0] TOG_OFF = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_ready, push_toggle;
    logic [15:0] push_data;
    logic        clear, start, stop, loop_en;
    logic [15:0] interval;
    obi_req_t    obi_req;
    obi_rsp_t    obi_rsp;
    logic        busy, done, err;
    logic [3:0]  count;

    always #5 clk = ~clk;

    gpio_obi_sequencer #(
        .GpioCount (16),
        .Depth     (8),
        .TimerWidth(16),
        .TargetAddr(BASE)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .push_toggle_i(push_toggle),
        .push_data_i  (push_data),
        .clear_i      (clear),
        .start_i      (start),
        .stop_i       (stop),
        .loop_i       (loop_en),
        .interval_i   (interval),
        .obi_req_o    (obi_req),
        .obi_rsp_i    (obi_rsp),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .count_o      (count)
    );

    // Monitor-owned history; the test reads it relative to snapshot bases.
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          req_start [$];
    int          rv_cyc [$];
    int          done_total = 0;
    int          cyc = 0;
    logic        req_prev = 1'b0;
    int          wb = 0, sb = 0, rb = 0, db = 0;

    // Responder: gnt after gnt_delay stalled cycles, rvalid one cycle after gnt.
    int   gnt_delay = 0;
    int   err_at = -1;
    int   wait_ctr = 0;
    logic gnt;
    logic rvalid_q = 1'b0;
    logic rerr_q = 1'b0;

    assign gnt               = obi_req.req && (wait_ctr >= gnt_delay);
    assign obi_rsp.gnt       = gnt;
    assign obi_rsp.rvalid    = rvalid_q;
    assign obi_rsp.r.err     = rerr_q;
    assign obi_rsp.r.rdata   = 32'h0;
    assign obi_rsp.r.rid     = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            wait_ctr <= 0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            wait_ctr <= (obi_req.req && !gnt) ? wait_ctr + 1 : 0;
            rvalid_q <= obi_req.req && gnt;
            rerr_q   <= obi_req.req && gnt && ((wr_addr.size() - 1 - wb) == err_at);
        end
    end

    always @(negedge clk) begin
        if (obi_req.req && gnt) begin
            wr_addr.push_back(obi_req.a.addr);
            wr_data.push_back(obi_req.a.wdata);
        end
        if (obi_req.req && !req_prev) req_start.push_back(cyc);
        if (obi_rsp.rvalid && obi_req.rready) rv_cyc.push_back(cyc);
        if (done) done_total = done_total + 1;
        req_prev = obi_req.req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int total = 0;
    int bad = 0;

    function automatic int nwr();
        return wr_addr.size() - wb;
    endfunction
    function automatic int ndone();
        return done_total - db;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic mon_clear();
        wb = wr_addr.size();
        sb = req_start.size();
        rb = rv_cyc.size();
        db = done_total;
    endtask

    task automatic do_push(input logic t, input logic [15:0] d);
        push_valid  = 1'b1;
        push_toggle = t;
        push_data   = d;
        step();
        push_valid  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_start(input logic lp, input int iv, output int c);
        loop_en  = lp;
        interval = 16'(iv);
        start    = 1'b1;
        c        = cyc;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            step();
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'h0);
    endtask

    // Reference: every stored entry is written once in order to BASE + its
    // register offset; an error ends the run after the failing write; the
    // next request starts interval+1 cycles after each response.
    task automatic play(input string tag, input int n, input int iv, input int gd, input int ea,
                        input int exp_w, input int exp_d, input logic exp_e);
        logic [15:0] dat [8];
        logic        tog [8];
        int          c;
        do_clear();
        for (int i = 0; i < n; i++) begin
            dat[i] = 16'($urandom);
            tog[i] = 1'($urandom_range(0, 1));
            do_push(tog[i], dat[i]);
        end
        check({tag, "_count"}, 32'(count), 32'(n));
        gnt_delay = gd;
        err_at    = ea;
        mon_clear();
        do_start(1'b0, iv, c);
        wait_idle(tag, 3000);
        repeat (3) step();
        check({tag, "_nwr"}, 32'(nwr()), 32'(exp_w));
        for (int i = 0; i < exp_w && i < nwr(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[wb + i], BASE + (tog[i] ? TOG_OFF : OUT_OFF));
            check($sformatf("%s_data%0d", tag, i), wr_data[wb + i], {16'h0, dat[i]});
        end
        if (req_start.size() > sb)
            check({tag, "_first_req"}, 32'(req_start[sb]), 32'(c + 1));
        for (int k = 0; k < nwr() - 1 && (rb + k) < rv_cyc.size() && (sb + k + 1) < req_start.size(); k++)
            check($sformatf("%s_gap%0d", tag, k), 32'(req_start[sb + k + 1] - rv_cyc[rb + k]), 32'(iv + 1));
        check({tag, "_done"}, 32'(ndone()), 32'(exp_d));
        check({tag, "_err"}, 32'(err), 32'(exp_e));
        gnt_delay = 0;
        err_at    = -1;
    endtask

    typedef struct {
        int   n;
        int   iv;
        int   gd;
        int   ea;
        int   exp_w;
        int   exp_d;
        logic exp_e;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [15:0] loop_exp [5];
        int c, n, rn, riv, rgd, rea;

        vecs[0] = '{n: 1, iv: 0, gd: 0, ea: -1, exp_w: 1, exp_d: 1, exp_e: 1'b0};
        vecs[1] = '{n: 4, iv: 2, gd: 1, ea: -1, exp_w: 4, exp_d: 1, exp_e: 1'b0};
        vecs[2] = '{n: 8, iv: 0, gd: 0, ea: -1, exp_w: 8, exp_d: 1, exp_e: 1'b0};
        vecs[3] = '{n: 3, iv: 1, gd: 2, ea: 1,  exp_w: 2, exp_d: 0, exp_e: 1'b1};
        vecs[4] = '{n: 5, iv: 7, gd: 0, ea: 4,  exp_w: 5, exp_d: 0, exp_e: 1'b1};

        rst = 1'b1; push_valid = 1'b0; push_toggle = 1'b0; push_data = '0;
        clear = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; interval = '0;
        repeat (3) step();
        check("rst_req", 32'(obi_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(push_ready), 32'h1);
        rst = 1'b0;
        step();

        // Two entries, interval 4.
        mon_clear();
        do_push(1'b0, 16'hA5A5);
        do_push(1'b1, 16'h0001);
        do_start(1'b0, 4, c);
        wait_idle("tp1", 200);
        step();
        check("tp1_nwr", 32'(nwr()), 32'd2);
        check("tp1_addr0", wr_addr[wb], BASE + OUT_OFF);
        check("tp1_data0", wr_data[wb], 32'h0000_A5A5);
        check("tp1_addr1", wr_addr[wb + 1], BASE + TOG_OFF);
        check("tp1_data1", wr_data[wb + 1], 32'h0000_0001);
        check("tp1_first_req", 32'(req_start[sb]), 32'(c + 1));
        check("tp1_gap", 32'(req_start[sb + 1] - rv_cyc[rb]), 32'd5);
        check("tp1_done", 32'(ndone()), 32'd1);
        check("tp1_busy", 32'(busy), 32'h0);

        // Looping playback stopped during the response of entry 1.
        do_clear();
        do_push(1'b0, 16'h0011);
        do_push(1'b1, 16'h0022);
        do_push(1'b0, 16'h0033);
        loop_exp[0] = 16'h0011; loop_exp[1] = 16'h0022; loop_exp[2] = 16'h0033;
        loop_exp[3] = 16'h0011; loop_exp[4] = 16'h0022;
        mon_clear();
        do_start(1'b1, 0, c);
        n = 0;
        while (nwr() < 5 && n < 200) begin
            step();
            n++;
        end
        check("tp2_reach", 32'(nwr() >= 5), 32'h1);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("tp2", 50);
        repeat (5) step();
        check("tp2_nwr", 32'(nwr()), 32'd5);
        for (int i = 0; i < 5 && i < nwr(); i++)
            check($sformatf("tp2_data%0d", i), wr_data[wb + i], {16'h0, loop_exp[i]});
        check("tp2_done", 32'(ndone()), 32'd1);

        // Six-cycle grant stall with a stop inside it.
        do_clear();
        do_push(1'b0, 16'hBEEF);
        do_push(1'b1, 16'h0F0F);
        mon_clear();
        gnt_delay = 6;
        do_start(1'b0, 2, c);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tp3_req%0d", i), 32'(obi_req.req), 32'h1);
            check($sformatf("tp3_addr%0d", i), obi_req.a.addr, BASE + OUT_OFF);
            check($sformatf("tp3_wdata%0d", i), obi_req.a.wdata, 32'h0000_BEEF);
            stop = (i == 2);
            step();
        end
        stop = 1'b0;
        wait_idle("tp3", 50);
        repeat (3) step();
        check("tp3_nwr", 32'(nwr()), 32'd1);
        check("tp3_done", 32'(ndone()), 32'd1);
        gnt_delay = 0;

        // Error response on entry 0, then a clean restart.
        do_clear();
        do_push(1'b0, 16'h1234);
        do_push(1'b0, 16'h5678);
        mon_clear();
        err_at = 0;
        do_start(1'b0, 1, c);
        wait_idle("tp4", 50);
        repeat (5) step();
        check("tp4_err", 32'(err), 32'h1);
        check("tp4_busy", 32'(busy), 32'h0);
        check("tp4_done", 32'(ndone()), 32'd0);
        check("tp4_nwr", 32'(nwr()), 32'd1);
        err_at = -1;
        mon_clear();
        do_start(1'b0, 1, c);
        check("tp4_err_cleared", 32'(err), 32'h0);
        wait_idle("tp4b", 50);
        step();
        check("tp4b_nwr", 32'(nwr()), 32'd2);
        check("tp4b_done", 32'(ndone()), 32'd1);

        // Full buffer, start+clear collision, empty start, same-cycle push.
        do_clear();
        for (int i = 0; i < 8; i++) do_push(1'b0, 16'(i));
        check("tp5_count8", 32'(count), 32'd8);
        check("tp5_ready0", 32'(push_ready), 32'h0);
        do_push(1'b0, 16'hDEAD);
        check("tp5_ninth", 32'(count), 32'd8);
        mon_clear();
        clear = 1'b1; start = 1'b1; interval = '0; loop_en = 1'b0;
        step();
        clear = 1'b0; start = 1'b0;
        check("tp5_clr_count", 32'(count), 32'd0);
        check("tp5_clr_busy", 32'(busy), 32'h0);
        repeat (4) step();
        check("tp5_clr_nwr", 32'(nwr()), 32'd0);
        check("tp5_clr_done", 32'(ndone()), 32'd0);
        mon_clear();
        do_start(1'b0, 0, c);
        check("tp5_empty_busy", 32'(busy), 32'h0);
        check("tp5_empty_done", 32'(done), 32'h1);
        step();
        check("tp5_empty_done_end", 32'(done), 32'h0);
        check("tp5_empty_nwr", 32'(nwr()), 32'd0);
        mon_clear();
        push_valid = 1'b1; push_toggle = 1'b1; push_data = 16'h5555; start = 1'b1;
        step();
        push_valid = 1'b0; start = 1'b0;
        check("tp5_sp_busy", 32'(busy), 32'h1);
        check("tp5_sp_count", 32'(count), 32'd1);
        wait_idle("tp5_sp", 50);
        step();
        check("tp5_sp_nwr", 32'(nwr()), 32'd1);
        check("tp5_sp_addr", wr_addr[wb], BASE + TOG_OFF);
        check("tp5_sp_data", wr_data[wb], 32'h0000_5555);
        gnt_delay = 10;
        do_start(1'b0, 0, c);
        push_valid = 1'b1; push_data = 16'h7777;
        check("tp5_busy_ready", 32'(push_ready), 32'h0);
        step();
        push_valid = 1'b0;
        check("tp5_busy_count", 32'(count), 32'd1);
        wait_idle("tp5_busy", 50);
        gnt_delay = 0;
        mon_clear();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("tp5_idle_stop_busy", 32'(busy), 32'h0);
        check("tp5_idle_stop_done", 32'(ndone()), 32'd0);

        // Stop during WAIT, then reset during WAIT.
        do_clear();
        do_push(1'b0, 16'hAAAA);
        do_push(1'b1, 16'hBBBB);
        mon_clear();
        do_start(1'b0, 10, c);
        n = 0;
        while (rv_cyc.size() <= rb && n < 50) begin step(); n++; end
        step();
        check("tp6_wait_busy", 32'(busy), 32'h1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("tp6_stop_busy", 32'(busy), 32'h0);
        check("tp6_stop_done", 32'(done), 32'h1);
        check("tp6_stop_nwr", 32'(nwr()), 32'd1);
        mon_clear();
        do_start(1'b0, 10, c);
        n = 0;
        while (rv_cyc.size() <= rb && n < 50) begin step(); n++; end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("tp6_rst_req", 32'(obi_req.req), 32'h0);
        check("tp6_rst_busy", 32'(busy), 32'h0);
        check("tp6_rst_count", 32'(count), 32'd0);
        repeat (12) step();
        check("tp6_rst_nwr", 32'(nwr()), 32'd1);

        for (int i = 0; i < 5; i++)
            play($sformatf("vec%0d", i), vecs[i].n, vecs[i].iv, vecs[i].gd, vecs[i].ea,
                 vecs[i].exp_w, vecs[i].exp_d, vecs[i].exp_e);

        for (int r = 0; r < 8; r++) begin
            rn  = $urandom_range(1, 8);
            riv = $urandom_range(0, 5);
            rgd = $urandom_range(0, 3);
            rea = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
            play($sformatf("rnd%0d", r), rn, riv, rgd, rea,
                 (rea >= 0) ? rea + 1 : rn, (rea >= 0) ? 0 : 1, 1'(rea >= 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
